// File: rtl/kbd_event_fifo_if.sv
// Key-event FIFO bus: scan-code producer side plus the consumer pop/status side.
// The master modport is the surrounding logic (PS/2 receiver, XT converter, consumer).
interface kbd_event_fifo_if #(
  parameter int CNT_W = 5
);
  logic [7:0]       at_code;
  logic             at_valid;
  logic [7:0]       xt_code;
  logic             kb_ack;
  logic             ovf_clr;
  logic [7:0]       kb_ch;
  logic             kb_ext;
  logic             kb_hit;
  logic             kb_tr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output at_code, at_valid, xt_code, kb_ack, ovf_clr,
    input  kb_ch, kb_ext, kb_hit, kb_tr, count, overflow
  );

  modport slave (
    input  at_code, at_valid, xt_code, kb_ack, ovf_clr,
    output kb_ch, kb_ext, kb_hit, kb_tr, count, overflow
  );
endinterface

// File: rtl/kbd_event_fifo.sv
// First-word-fall-through queue of translated PS/2 key events with break/extended prefix folding.
// Optional feature: define KBD_EXT_PREFIX_EN to treat 8'hE0 as an extended-key prefix.
module kbd_event_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  kbd_event_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
`ifdef KBD_EXT_PREFIX_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             brk;
  logic             tr_q;
  logic             ovf_q;

  logic             is_break;
  logic             is_prefix;
  logic             is_code;
  logic             not_empty;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             push_drop;
  logic [7:0]       ev_code;
  logic [EW-1:0]    ev_word;
  logic [EW-1:0]    head;

  assign is_break = bus.at_valid && (bus.at_code == 8'hF0);

`ifdef KBD_EXT_PREFIX_EN
  logic ext;
  assign is_prefix = bus.at_valid && (bus.at_code == 8'hE0);
  assign ev_word   = {ext, ev_code};
`else
  assign is_prefix = 1'b0;
  assign ev_word   = ev_code;
`endif

  assign is_code   = bus.at_valid && !is_break && !is_prefix;
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign pop       = bus.kb_ack && not_empty;
  // A pop in the same cycle frees a slot, so a push into a full queue still lands.
  assign push_ok   = is_code && (!full || pop);
  assign push_drop = is_code && full && !pop;

  assign ev_code = bus.xt_code[7] ? bus.xt_code : {brk, bus.xt_code[6:0]};
  assign head    = mem[rd_ptr];

  assign bus.kb_hit   = not_empty;
  assign bus.kb_ch    = not_empty ? head[7:0] : 8'h00;
`ifdef KBD_EXT_PREFIX_EN
  assign bus.kb_ext   = not_empty ? head[8] : 1'b0;
`else
  assign bus.kb_ext   = 1'b0;
`endif
  assign bus.count    = count_q;
  assign bus.kb_tr    = tr_q;
  assign bus.overflow = ovf_q;

  always_ff @(posedge clock) begin
    if (reset_n && push_ok) begin
      mem[wr_ptr] <= ev_word;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      brk     <= 1'b0;
      tr_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (is_break) begin
        brk <= 1'b1;
      end else if (is_code) begin
        brk <= 1'b0;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
        tr_q   <= ~tr_q;
      end

      if (push_ok && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CNT_W'(1);
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (push_drop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef KBD_EXT_PREFIX_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ext <= 1'b0;
    end else if (is_prefix) begin
      ext <= 1'b1;
    end else if (is_code) begin
      ext <= 1'b0;
    end
  end
`endif

endmodule
